hdlc_tx_scheduler: RTL and testbench

//  Shares the HDLC core Tx path between two frame sources. Round-robin grant per frame;

---
 rtl/hdlc_tx_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_hdlc_tx_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_scheduler.sv
// Round-robin sharing of the HDLC core Tx path between two byte-stream frame sources.
// Optional per-requester frame/error counters are enabled by HDLC_TXSCHED_STATS_EN.
module hdlc_tx_scheduler #(
  parameter int unsigned MAX_BYTES     = 126,
  parameter int unsigned POLL_INTERVAL = 8,
  parameter int unsigned DONE_TIMEOUT  = 4096
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0_Valid,
  input  logic [7:0]  Req0_Data,
  input  logic        Req0_Last,
  output logic        Req0_Ready,
  input  logic        Req1_Valid,
  input  logic [7:0]  Req1_Data,
  input  logic        Req1_Last,
  output logic        Req1_Ready,
  output logic [1:0]  Grant,
  output logic        Busy,
  output logic        FrameDone,
  output logic        FrameErr,
  output logic [1:0]  ErrCode,
  output logic [2:0]  Address,
  output logic        WriteEnable,
  output logic        ReadEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut
`ifdef HDLC_TXSCHED_STATS_EN
  ,
  output logic [15:0] Frames0,
  output logic [15:0] Frames1,
  output logic [15:0] Errors
`endif
);

  localparam int unsigned TimerW = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned PollW  = $clog2(POLL_INTERVAL);
  localparam logic [8:0]  MaxBytes9 = 9'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitDone,
    StDrain,
    StAbort
  } stateT;

  stateT             state;
  logic [7:0]        count;
  logic [TimerW-1:0] timer;
  logic [PollW-1:0]  pollCnt;
  logic              rrPtr;
  logic              sample;
  logic [1:0]        errKind;

  logic       inLoad;
  logic       accValid;
  logic       accLast;
  logic [7:0] accData;
  logic [8:0] byteNum;
  logic       unusedDataOut;

  assign inLoad     = (state == StLoad) || (state == StDrain);
  assign Req0_Ready = inLoad && Grant[0];
  assign Req1_Ready = inLoad && Grant[1];
  assign Busy       = (state != StIdle);
  assign byteNum    = {1'b0, count} + 9'd1;
  // Only Tx_Done is of interest in the status register.
  assign unusedDataOut = ^DataOut[7:1];

  always_comb begin
    accValid = 1'b0;
    accLast  = 1'b0;
    accData  = 8'h00;
    if (Grant[1]) begin
      accValid = Req1_Valid && Req1_Ready;
      accLast  = Req1_Last;
      accData  = Req1_Data;
    end else begin
      accValid = Req0_Valid && Req0_Ready;
      accLast  = Req0_Last;
      accData  = Req0_Data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= StIdle;
      count       <= 8'h00;
      timer       <= '0;
      pollCnt     <= '0;
      rrPtr       <= 1'b1;
      sample      <= 1'b0;
      errKind     <= 2'b00;
      Grant       <= 2'b00;
      FrameDone   <= 1'b0;
      FrameErr    <= 1'b0;
      ErrCode     <= 2'b00;
      Address     <= 3'd0;
      WriteEnable <= 1'b0;
      ReadEnable  <= 1'b0;
      DataIn      <= 8'h00;
`ifdef HDLC_TXSCHED_STATS_EN
      Frames0     <= 16'h0000;
      Frames1     <= 16'h0000;
      Errors      <= 16'h0000;
`endif
    end else begin
      WriteEnable <= 1'b0;
      ReadEnable  <= 1'b0;
      FrameDone   <= 1'b0;
      FrameErr    <= 1'b0;
      // DataOut answers the read strobe of the previous cycle.
      sample      <= ReadEnable;
      unique case (state)
        StIdle: begin
          count <= 8'h00;
          if (Req0_Valid && Req1_Valid) begin
            Grant <= rrPtr ? 2'b01 : 2'b10;
            rrPtr <= ~rrPtr;
            state <= StLoad;
          end else if (Req0_Valid) begin
            Grant <= 2'b01;
            rrPtr <= 1'b0;
            state <= StLoad;
          end else if (Req1_Valid) begin
            Grant <= 2'b10;
            rrPtr <= 1'b1;
            state <= StLoad;
          end
        end
        StLoad: begin
          if (accValid) begin
            WriteEnable <= 1'b1;
            Address     <= 3'd1;
            DataIn      <= accData;
            count       <= count + 8'd1;
            if (accLast) begin
              state <= StStart;
            end else if (byteNum == MaxBytes9) begin
              state <= StDrain;
            end
          end
        end
        StStart: begin
          WriteEnable <= 1'b1;
          Address     <= 3'd0;
          DataIn      <= 8'h02;
          timer       <= '0;
          pollCnt     <= '0;
          state       <= StWaitDone;
        end
        StWaitDone: begin
          if (sample && DataOut[0]) begin
            FrameDone <= 1'b1;
            Grant     <= 2'b00;
            state     <= StIdle;
`ifdef HDLC_TXSCHED_STATS_EN
            if (Grant[0] && (Frames0 != 16'hFFFF)) Frames0 <= Frames0 + 16'd1;
            if (Grant[1] && (Frames1 != 16'hFFFF)) Frames1 <= Frames1 + 16'd1;
`endif
          end else if (timer == TimerW'(DONE_TIMEOUT)) begin
            errKind <= 2'b10;
            state   <= StAbort;
          end else begin
            timer <= timer + TimerW'(1);
            if (pollCnt == '0) begin
              ReadEnable <= 1'b1;
              Address    <= 3'd0;
            end
            pollCnt <= (pollCnt == PollW'(POLL_INTERVAL - 1)) ? '0 : pollCnt + PollW'(1);
          end
        end
        StDrain: begin
          if (accValid && accLast) begin
            errKind <= 2'b01;
            state   <= StAbort;
          end
        end
        StAbort: begin
          WriteEnable <= 1'b1;
          Address     <= 3'd0;
          DataIn      <= 8'h04;
          FrameErr    <= 1'b1;
          ErrCode     <= errKind;
          Grant       <= 2'b00;
          state       <= StIdle;
`ifdef HDLC_TXSCHED_STATS_EN
          if (Errors != 16'hFFFF) Errors <= Errors + 16'd1;
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Scoreboard bench for hdlc_tx_scheduler: expected core writes and frame events are queued
// by the stimulus and consumed by independent monitors.
module tb_hdlc_tx_scheduler;

  localparam int MaxBytes = 126;
  localparam int PollInt  = 8;
  localparam int Timeout  = 4096;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Req0_Valid = 1'b0, Req0_Last = 1'b0, Req1_Valid = 1'b0, Req1_Last = 1'b0;
  logic [7:0] Req0_Data = 8'h00, Req1_Data = 8'h00;
  logic       Req0_Ready, Req1_Ready;
  logic [1:0] Grant, ErrCode;
  logic       Busy, FrameDone, FrameErr, WriteEnable, ReadEnable;
  logic [2:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut = 8'h00;
`ifdef HDLC_TXSCHED_STATS_EN
  logic [15:0] Frames0, Frames1, Errors;
`endif

  hdlc_tx_scheduler #(
    .MAX_BYTES    (MaxBytes),
    .POLL_INTERVAL(PollInt),
    .DONE_TIMEOUT (Timeout)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req0_Valid (Req0_Valid),
    .Req0_Data  (Req0_Data),
    .Req0_Last  (Req0_Last),
    .Req0_Ready (Req0_Ready),
    .Req1_Valid (Req1_Valid),
    .Req1_Data  (Req1_Data),
    .Req1_Last  (Req1_Last),
    .Req1_Ready (Req1_Ready),
    .Grant      (Grant),
    .Busy       (Busy),
    .FrameDone  (FrameDone),
    .FrameErr   (FrameErr),
    .ErrCode    (ErrCode),
    .Address    (Address),
    .WriteEnable(WriteEnable),
    .ReadEnable (ReadEnable),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
`ifdef HDLC_TXSCHED_STATS_EN
    ,
    .Frames0    (Frames0),
    .Frames1    (Frames1),
    .Errors     (Errors)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] g;  // 2'b11: grant not checked
    logic [2:0] a;
    logic [7:0] d;
  } wrT;
  typedef struct packed {
    logic       isErr;
    logic [1:0] code;
  } evT;

  wrT wq[$];
  evT eq[$];
  int errors = 0;
  int checks = 0;
  bit coreDone = 1'b0;
  bit rdSeen = 1'b0;
  int cyc = 0;
  int lastEn = -1000;
  int lastRd = -1000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: status read returns Tx_Done when coreDone is set.
  always @(negedge Clk) begin
    DataOut = (rdSeen && coreDone) ? 8'h01 : 8'h00;
    rdSeen  = ReadEnable;
  end

  // Bus monitor
  always @(negedge Clk) begin
    wrT w;
    cyc++;
    if (WriteEnable && ReadEnable) check("wr_rd_overlap", 16'd1, 16'd0);
    if (Req0_Ready && !Grant[0]) check("ready0_ungranted", 16'd1, 16'd0);
    if (Req1_Ready && !Grant[1]) check("ready1_ungranted", 16'd1, 16'd0);
    if (WriteEnable) begin
      if (wq.size() == 0) begin
        check("unexpected_write", {5'd0, Address, DataIn}, 16'hFFFF);
      end else begin
        w = wq.pop_front();
        check("write_addr_data", {5'd0, Address, DataIn}, {5'd0, w.a, w.d});
        if (w.g != 2'b11) check("write_grant", {14'd0, Grant}, {14'd0, w.g});
      end
      if (Address == 3'd0 && DataIn == 8'h02) lastEn = cyc;
    end
    if (ReadEnable) begin
      check("read_addr", {13'd0, Address}, 16'd0);
      if (lastEn > lastRd) check("first_poll_gap", 16'(cyc - lastEn), 16'd1);
      else check("poll_gap", 16'(cyc - lastRd), 16'(PollInt));
      lastRd = cyc;
    end
  end

  // Frame event monitor
  always @(negedge Clk) begin
    evT e;
    if (FrameDone || FrameErr) begin
      if (eq.size() == 0) begin
        check("unexpected_event", {14'd0, FrameErr, FrameDone}, 16'd0);
      end else begin
        e = eq.pop_front();
        check("event_kind", {14'd0, FrameErr, FrameDone}, {14'd0, e.isErr, !e.isErr});
        if (e.isErr) check("err_code", {14'd0, ErrCode}, {14'd0, e.code});
        else check("done_grant", {14'd0, Grant}, 16'd0);
      end
    end
  end

  // outcome: 0 done, 1 oversize, 2 timeout, 3 cut by reset
  task automatic expectFrame(input logic [1:0] g, input int n, input logic [7:0] base,
                             input logic [7:0] step, input int outcome);
    int nw;
    nw = (n > MaxBytes) ? MaxBytes : n;
    for (int i = 0; i < nw; i++) wq.push_back({g, 3'd1, 8'(base + 8'(i) * step)});
    case (outcome)
      0: begin
        wq.push_back({2'b11, 3'd0, 8'h02});
        eq.push_back({1'b0, 2'b00});
      end
      1: begin
        wq.push_back({2'b11, 3'd0, 8'h04});
        eq.push_back({1'b1, 2'b01});
      end
      2: begin
        wq.push_back({2'b11, 3'd0, 8'h02});
        wq.push_back({2'b11, 3'd0, 8'h04});
        eq.push_back({1'b1, 2'b10});
      end
      default: ;
    endcase
  endtask

  task automatic sendFrame(input int req, input int n, input logic [7:0] base,
                           input logic [7:0] step, input bit withLast);
    int i = 0;
    int guard = 0;
    bit acc;
    logic [7:0] d;
    while (i < n && guard < 2000) begin
      @(negedge Clk);
      d = base + 8'(i) * step;
      if (req == 0) begin
        Req0_Valid = 1'b1; Req0_Data = d; Req0_Last = withLast && (i == n - 1);
        acc = Req0_Ready;
      end else begin
        Req1_Valid = 1'b1; Req1_Data = d; Req1_Last = withLast && (i == n - 1);
        acc = Req1_Ready;
      end
      @(posedge Clk);
      if (acc) i++;
      guard++;
    end
    @(negedge Clk);
    if (req == 0) begin Req0_Valid = 1'b0; Req0_Last = 1'b0; end
    else begin Req1_Valid = 1'b0; Req1_Last = 1'b0; end
    if (guard >= 2000) check("send_timeout", 16'(i), 16'(n));
  endtask

  task automatic waitIdle(input int bound);
    int c = 0;
    while ((wq.size() != 0 || eq.size() != 0 || Busy) && c < bound) begin
      @(negedge Clk);
      c++;
    end
    check("wait_idle_timeout", 16'(c >= bound), 16'd0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_grant", {14'd0, Grant}, 16'd0);
    check("rst_busy_ready", {13'd0, Busy, Req0_Ready, Req1_Ready}, 16'd0);
    check("rst_strobes", {12'd0, WriteEnable, ReadEnable, FrameDone, FrameErr}, 16'd0);
    check("rst_addr_data_err", {3'd0, Address, DataIn, ErrCode}, 16'd0);
    Rst = 1'b0;
    coreDone = 1'b1;

    // Simultaneous requests: 0 wins first, then alternation
    for (int r = 0; r < 2; r++) begin
      expectFrame(2'b01, 1, 8'h11 + 8'(r * 2), 8'h00, 0);
      expectFrame(2'b10, 1, 8'h22 + 8'(r * 2), 8'h00, 0);
      fork
        sendFrame(0, 1, 8'h11 + 8'(r * 2), 8'h00, 1'b1);
        sendFrame(1, 1, 8'h22 + 8'(r * 2), 8'h00, 1'b1);
      join
      waitIdle(500);
    end

    expectFrame(2'b01, 3, 8'hAA, 8'h11, 0);
    sendFrame(0, 3, 8'hAA, 8'h11, 1'b1);
    waitIdle(500);
    check("grant_after_done", {14'd0, Grant}, 16'd0);

    expectFrame(2'b10, 130, 8'h00, 8'h01, 1);
    sendFrame(1, 130, 8'h00, 8'h01, 1'b1);
    waitIdle(500);

    coreDone = 1'b0;
    expectFrame(2'b01, 1, 8'h5A, 8'h00, 2);
    sendFrame(0, 1, 8'h5A, 8'h00, 1'b1);
    waitIdle(Timeout + 200);
    check("errcode_hold", {14'd0, ErrCode}, 16'h2);
    coreDone = 1'b1;

    // Reset mid-LOAD after two bytes
    expectFrame(2'b01, 2, 8'hD1, 8'h01, 3);
    sendFrame(0, 2, 8'hD1, 8'h01, 1'b0);
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("midrst_grant", {14'd0, Grant}, 16'd0);
    check("midrst_busy_ready", {13'd0, Busy, Req0_Ready, Req1_Ready}, 16'd0);
    @(negedge Clk);
    Rst = 1'b0;
    check("midrst_writes_seen", 16'(wq.size()), 16'd0);
    expectFrame(2'b01, 1, 8'h77, 8'h00, 0);
    sendFrame(0, 1, 8'h77, 8'h00, 1'b1);
    waitIdle(500);

`ifdef HDLC_TXSCHED_STATS_EN
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      expectFrame(2'b01, 2, 8'h30, 8'h01, 0);
      sendFrame(0, 2, 8'h30, 8'h01, 1'b1);
      waitIdle(500);
    end
    expectFrame(2'b10, 130, 8'h80, 8'h01, 1);
    sendFrame(1, 130, 8'h80, 8'h01, 1'b1);
    waitIdle(500);
    check("stats_frames0", Frames0, 16'd2);
    check("stats_frames1", Frames1, 16'd0);
    check("stats_errors", Errors, 16'd1);
`endif

    check("queues_empty", 16'(wq.size() + eq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
